// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// forwarding selectors.
package hazard_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } hz_state_e;

  // ALU operand source select codes
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] LOAD_SRC_DEFAULT = 2'b01;
  localparam int         CNT_W            = 6;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand bypass selector: picks the youngest in-flight producer of the
// EX-stage source register, with the M stage winning over W.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  // NOTE: assigning a default before any branch keeps this block free of
  // inferred latches; every always_comb output gets one first.
  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and a
// RUN/BUSY sequencer that parks the pipe while a multi-cycle MUL/DIV runs.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = 63,
  parameter logic [1:0]  LOAD_SRC    = LOAD_SRC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        MultiCycleE,
  input  logic        mdu_done,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        mdu_start,
  output logic        mdu_timeout,
  output logic [31:0] stall_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MDU_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      stall_count_q;
  logic             load_use;

  hazard_fwd_sel u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardAE)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardBE)
  );

  assign load_use = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Control outputs must react in the same cycle as the hazard they cover,
  // so they are decoded from the current state and inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    mdu_start = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (MultiCycleE) begin
          StallF    = 1'b1;
          StallD    = 1'b1;
          StallE    = 1'b1;
          FlushM    = 1'b1;
          mdu_start = 1'b1;
          cnt_d     = '0;
          state_d   = ST_BUSY;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mdu_done) begin
          state_d = ST_RUN;
        end else if (cnt_q == TIMEOUT_CNT) begin
          // Give up on the MDU: flag it and let the pipe move on.
          timeout_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (!rst_n) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      mdu_start = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (StallF && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign mdu_timeout = timeout_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized scoreboard bench for hazard_controller: a driver pushes expected
// responses from a behavioural model, a monitor pops and compares each cycle.
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam int MDU_TIMEOUT = 63;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, MultiCycleE, mdu_done;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mdu_start, mdu_timeout;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  hazard_controller #(.MDU_TIMEOUT(MDU_TIMEOUT), .LOAD_SRC(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
    .mdu_done(mdu_done),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mdu_start(mdu_start), .mdu_timeout(mdu_timeout), .stall_count(stall_count)
  );

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwm, regww;
    logic [1:0] rsrc;
    logic       pcsrc, mc, done, rst_n;
  } stim_t;

  // ctrl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, mdu_start}
  typedef struct packed {
    logic [6:0]  ctrl;
    logic [3:0]  fwd;
    logic        timeout;
    logic [31:0] scount;
  } resp_t;

  resp_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: an MDU op in flight and how long it has waited so far.
  bit          m_in_op;
  int          m_waited;
  bit          m_timeout;
  logic [31:0] m_stalls;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
    if (s.regwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.regww && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_cycle(input stim_t s, output resp_t e);
    bit load_use;
    e         = '0;
    e.fwd     = {ref_fwd(s.rs1e, s), ref_fwd(s.rs2e, s)};
    e.timeout = m_timeout;
    e.scount  = m_stalls;
    if (!s.rst_n) begin
      m_in_op = 0; m_waited = 0; m_timeout = 0; m_stalls = '0;
      return;
    end
    load_use = (s.rsrc == 2'b01) && (s.rde != 0) && (s.rde == s.rs1d || s.rde == s.rs2d);
    if (!m_in_op) begin
      if (s.pcsrc)     e.ctrl = 7'b000_1100;
      else if (s.mc) begin
        e.ctrl   = 7'b111_0011;
        m_in_op  = 1;
        m_waited = 0;
      end
      else if (load_use) e.ctrl = 7'b110_0100;
    end else begin
      if (s.done) m_in_op = 0;
      else if (m_waited == MDU_TIMEOUT) begin
        m_timeout = 1;
        m_in_op   = 0;
      end else begin
        e.ctrl = 7'b111_0010;
        m_waited++;
      end
    end
    if (e.ctrl[6] && m_stalls != 32'hFFFF_FFFF) m_stalls++;
  endtask

  task automatic apply(input stim_t s);
    Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e; RdE = s.rde;
    RdM = s.rdm; RdW = s.rdw; RegWriteM = s.regwm; RegWriteW = s.regww;
    ResultSrcE = s.rsrc; PCSrcE = s.pcsrc; MultiCycleE = s.mc;
    mdu_done = s.done; rst_n = s.rst_n;
  endtask

  task automatic step(input stim_t s);
    resp_t e;
    @(posedge clk);
    #1;
    apply(s);
    model_cycle(s, e);
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rs1d  = 5'($urandom_range(0, 3));
    s.rs2d  = 5'($urandom_range(0, 3));
    s.rs1e  = 5'($urandom_range(0, 3));
    s.rs2e  = 5'($urandom_range(0, 3));
    s.rde   = 5'($urandom_range(0, 3));
    s.rdm   = 5'($urandom_range(0, 3));
    s.rdw   = 5'($urandom_range(0, 3));
    s.regwm = 1'($urandom);
    s.regww = 1'($urandom);
    s.rsrc  = 2'($urandom);
    s.pcsrc = ($urandom_range(0, 5) == 0);
    s.mc    = ($urandom_range(0, 9) == 0);
    s.done  = ($urandom_range(0, 3) == 0);
    s.rst_n = ($urandom_range(0, 249) != 0);
    return s;
  endfunction

  // Monitor: compares DUT outputs mid-cycle against the queued expectation.
  initial begin
    resp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.ctrl    = {StallF, StallD, StallE, FlushD, FlushE, FlushM, mdu_start};
        a.fwd     = {ForwardAE, ForwardBE};
        a.timeout = mdu_timeout;
        a.scount  = stall_count;
        check("ctrl", 64'(a.ctrl), 64'(e.ctrl));
        check("forward", 64'(a.fwd), 64'(e.fwd));
        check("status", {31'd0, a.timeout, a.scount}, {31'd0, e.timeout, e.scount});
      end
    end
  end

  initial begin
    stim_t       s;
    logic [31:0] base;
    int          k;

    apply(idle());
    rst_n = 1'b0;
    m_in_op = 0; m_waited = 0; m_timeout = 0; m_stalls = '0;
    @(posedge clk);
    s = idle(); s.rst_n = 1'b0; s.mc = 1'b1; s.pcsrc = 1'b1;
    step(s);
    step(idle());

    // M beats W on the same register; then W alone when RdM is x0
    s = idle(); s.rdm = 5; s.regwm = 1; s.rs1e = 5; s.rdw = 5; s.regww = 1;
    step(s);
    #1 check("fwd_m_priority", 64'(ForwardAE), 64'(2'b10));
    s.rdm = 0;
    step(s);
    #1 check("fwd_w_when_rdm0", 64'(ForwardAE), 64'(2'b01));

    // Load-use, then the same with a taken branch overriding it
    s = idle(); s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7;
    step(s);
    s.pcsrc = 1;
    step(s);
    step(idle());

    // MDU op completing four cycles after launch
    base = m_stalls;
    s = idle(); s.mc = 1;
    for (int i = 0; i < 4; i++) step(s);
    s.done = 1;
    step(s);
    step(idle());
    #1 check("mdu_done_stalls", 64'(stall_count), 64'(base + 32'd4));

    // Back-to-back MDU ops each get their own launch
    s = idle(); s.mc = 1;
    step(s); s.done = 1; step(s); s.done = 0; step(s); s.done = 1; step(s);
    step(idle());

    // MDU never answers: forced release and sticky flag
    base = m_stalls;
    s = idle(); s.mc = 1;
    for (int i = 0; i < 65; i++) step(s);
    step(idle());
    #1 check("timeout_stalls", 64'(stall_count), 64'(base + 32'd64));
    check("timeout_flag", 64'(mdu_timeout), 64'd1);
    step(idle());
    step(idle());
    #1 check("timeout_sticky", 64'(mdu_timeout), 64'd1);
    s = idle(); s.rst_n = 0;
    step(s);
    step(idle());
    #1 check("timeout_cleared", 64'(mdu_timeout), 64'd0);

    // Reset in the middle of a BUSY wait
    s = idle(); s.mc = 1;
    for (int i = 0; i < 3; i++) step(s);
    s.rst_n = 0;
    step(s);
    step(idle());
    #1 check("reset_mid_busy_cnt", 64'(stall_count), 64'd0);
    check("reset_mid_busy_start", 64'(mdu_start), 64'd0);

    for (int i = 0; i < 3000; i++) step(rand_stim());
    step(idle());

    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    #1 check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameters SHALL be: MDU_TIMEOUT, 63, max BUSY cycles before forced release (1..63); LOAD_SRC, 2'b01, ResultSrcE encoding that marks a load.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 Rs1D, Rs2D  in  5  decode-stage source registers.
REQ-005 Rs1E, Rs2E, RdE  in  5  execute-stage source and destination registers.
REQ-006 RdM, RdW  in  5  memory- and writeback-stage destination registers.
REQ-007 RegWriteM, RegWriteW  in  1  register-write enables for the M and W stages.
REQ-008 ResultSrcE  in  2  execute-stage result select.
REQ-009 PCSrcE  in  1  taken branch or jump resolved in EX.
REQ-010 MultiCycleE  in  1  EX holds a multi-cycle MUL/DIV op; mdu_done  in  1  MDU result valid.
REQ-011 StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers.
REQ-012 FlushD, FlushE, FlushM  out  1  bubble into IF/ID, ID/EX and EX/MEM.
REQ-013 ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 W, 10 M.
REQ-014 mdu_start  out  1  one-cycle MDU launch pulse; mdu_timeout  out  1  sticky error flag.
REQ-015 stall_count  out  32  count of cycles with StallF asserted.

Function
REQ-016 Forwarding SHALL be combinational and per operand: 10 if RegWriteM, RdM!=0 and RdM==Rs1E (Rs2E for B); else 01 under the same test using the W-stage signals; else 00. M has priority over W.
REQ-017 The FSM SHALL have exactly two states, RUN and BUSY, with a 6-bit cycle counter.
REQ-018 RUN, PCSrcE=1: FlushD=FlushE=1 and all stalls 0; this overrides the load-use and MDU checks in the same cycle.
REQ-019 RUN, PCSrcE=0, load-use detected: StallF=StallD=1, FlushE=1, StallE=0; load-use means ResultSrcE==LOAD_SRC, RdE!=0 and RdE matches Rs1D or Rs2D.
REQ-020 RUN, PCSrcE=0, MultiCycleE=1: StallF=StallD=StallE=1, FlushM=1, mdu_start=1, counter cleared, next state BUSY; this takes precedence over load-use.
REQ-021 BUSY, mdu_done=0: StallF=StallD=StallE=1, FlushM=1, mdu_start=0, counter incremented; PCSrcE and load-use are ignored.
REQ-022 BUSY, mdu_done=1: all stalls and flushes 0 in that cycle so ID/EX advances at the edge; next state RUN.
REQ-023 BUSY, counter==MDU_TIMEOUT and mdu_done=0: set mdu_timeout, release as in REQ-022, next state RUN. mdu_done and the timeout in the same cycle SHALL be treated as done, with no flag set.
REQ-024 mdu_start SHALL last exactly one cycle per MDU op; back-to-back MDU ops SHALL each get a fresh pulse on re-entry to RUN.
REQ-025 mdu_timeout SHALL stay set until reset.
REQ-026 stall_count SHALL increment on every cycle with StallF=1 and saturate at 32'hFFFFFFFF without wrapping.
REQ-027 With no hazard, all stall and flush outputs SHALL be 0.

Reset
REQ-028 While rst_n=0 at posedge clk: state RUN, counter 0, mdu_timeout 0, stall_count 0.
REQ-029 While rst_n=0, all stall, flush and mdu_start outputs SHALL be 0. Forward outputs stay combinational.
REQ-030 A reset during BUSY SHALL abandon the op without a second mdu_start; the MDU is reset on the same rst_n.

Structure
REQ-031 Package hazard_pkg SHALL hold: the FSM state encoding, the FWD_RF/FWD_W/FWD_M constants, and the LOAD_SRC default.
REQ-032 Forwarding SHALL be one sub-module, hazard_fwd_sel, instantiated once per operand. The FSM, stall/flush priority logic and counters SHALL stay in hazard_controller.

Verification
REQ-033 RdM=5, RegWriteM=1, Rs1E=5; also RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=0 instead -> ForwardAE=01.
REQ-034 ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=0 -> one cycle of StallF=StallD=FlushE=1; stall_count +1.
REQ-035 Same as REQ-034 plus PCSrcE=1 -> FlushD=FlushE=1, StallF=0, stall_count unchanged.
REQ-036 MultiCycleE=1, mdu_done asserted 4 cycles after start -> mdu_start one cycle, stalls for 4 cycles, release on the done cycle, stall_count +4.
REQ-037 MultiCycleE=1, mdu_done never asserted, MDU_TIMEOUT=63 -> release after 64 stalled cycles, mdu_timeout=1 and held; rst_n=0 clears it.
REQ-038 rst_n=0 asserted mid-BUSY -> next cycle state RUN, stalls 0, stall_count 0, no mdu_start.
